// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU self-test controller: opcodes, FSM states,
// the golden vector record and a helper that derives expected flags from a result.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLTU = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;

  localparam int NUM_VECTORS = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_sign;
  } vec_t;

  function automatic vec_t mk_vec(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] r);
    vec_t v;
    v.opcode     = op;
    v.a          = a;
    v.b          = b;
    v.exp_result = r;
    v.exp_zero   = (r == 32'd0);
    v.exp_sign   = r[31];
    return v;
  endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Golden vector table: combinational index -> vector record, zero latency.
// Out-of-range indices return an all-zero record.
module alu_bist_rom
  import alu_pkg::*;
(
  input  logic [4:0] idx,
  output vec_t       vec
);

  always_comb begin
    vec = '0;
    case (idx)
      5'd0:  vec = mk_vec(ALU_ADD,  32'd0,        32'd0,        32'd0);
      5'd1:  vec = mk_vec(ALU_ADD,  32'd1,        32'd1,        32'd2);
      5'd2:  vec = mk_vec(ALU_SUB,  32'd2,        32'd1,        32'd1);
      5'd3:  vec = mk_vec(ALU_SUB,  32'd1,        32'd2,        32'hFFFF_FFFF);
      5'd4:  vec = mk_vec(ALU_AND,  32'd5,        32'd1,        32'd1);
      5'd5:  vec = mk_vec(ALU_OR,   32'd4,        32'd1,        32'd5);
      5'd6:  vec = mk_vec(ALU_SLTU, 32'd4,        32'd5,        32'd1);
      5'd7:  vec = mk_vec(ALU_SLTU, 32'd5,        32'd4,        32'd0);
      // Signed compares straddle zero so an unsigned-only comparator is caught.
      5'd8:  vec = mk_vec(ALU_SLT,  32'd4,        32'd5,        32'd1);
      5'd9:  vec = mk_vec(ALU_SLT,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0);
      5'd10: vec = mk_vec(ALU_SLT,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1);
      5'd11: vec = mk_vec(ALU_SLT,  32'hFFFF_FFFF, 32'd0,        32'd1);
      5'd12: vec = mk_vec(ALU_SLT,  32'd0,        32'hFFFF_FFFE, 32'd0);
      5'd13: vec = mk_vec(ALU_SLT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
      5'd14: vec = mk_vec(ALU_SLT,  32'd0,        32'd2,        32'd1);
      5'd15: vec = mk_vec(ALU_SLT,  32'd1,        32'd0,        32'd0);
      5'd16: vec = mk_vec(ALU_SLT,  32'd2,        32'd2,        32'd0);
      5'd17: vec = mk_vec(ALU_SLT,  32'd0,        32'd0,        32'd0);
      5'd18: vec = mk_vec(ALU_SLT,  32'd9,        32'd5,        32'd0);
      default: vec = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test controller: drives 19 golden vectors, each held SETTLE_CYCLES+1 cycles,
// compares result/zero/sign on the CHECK edge; start is ignored while a run is busy.
module alu_bist
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_rega,
  output logic [31:0] alu_regb,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_sign,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic [4:0]  fail_index
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] LAST_IDX = 5'(NUM_VECTORS - 1);

  state_t      state, state_nxt;
  logic [4:0]  idx, idx_nxt, rom_addr;
  logic [3:0]  cnt, cnt_nxt;
  vec_t        rom_vec;
  logic [31:0] exp_result, exp_result_nxt;
  logic        exp_zero, exp_zero_nxt, exp_sign, exp_sign_nxt;
  logic [2:0]  opcode_nxt;
  logic [31:0] rega_nxt, regb_nxt;
  logic [7:0]  fail_count_nxt;
  logic [4:0]  fail_index_nxt;
  logic        busy_nxt, done_nxt, pass_nxt;
  logic        mismatch, load_vec;

  // The ROM always presents the vector that would be loaded next.
  assign rom_addr = (state == ST_CHECK) ? idx + 5'd1 : 5'd0;

  alu_bist_rom u_rom (
    .idx (rom_addr),
    .vec (rom_vec)
  );

  assign mismatch = (alu_result != exp_result) || (alu_zero != exp_zero) ||
                    (alu_sign != exp_sign);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    fail_count_nxt = fail_count;
    fail_index_nxt = fail_index;
    opcode_nxt     = alu_opcode;
    rega_nxt       = alu_rega;
    regb_nxt       = alu_regb;
    exp_result_nxt = exp_result;
    exp_zero_nxt   = exp_zero;
    exp_sign_nxt   = exp_sign;
    load_vec       = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt      = ST_WAIT;
          idx_nxt        = 5'd0;
          cnt_nxt        = CNT_LOAD;
          fail_count_nxt = 8'd0;
          fail_index_nxt = 5'd0;
          load_vec       = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (fail_count != 8'hFF) begin
            fail_count_nxt = fail_count + 8'd1;
          end
          if (fail_count == 8'd0) begin
            fail_index_nxt = idx;
          end
        end
        // After the last vector its operands stay on the bus.
        if (idx == LAST_IDX) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_WAIT;
          idx_nxt   = idx + 5'd1;
          cnt_nxt   = CNT_LOAD;
          load_vec  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (load_vec) begin
      opcode_nxt     = rom_vec.opcode;
      rega_nxt       = rom_vec.a;
      regb_nxt       = rom_vec.b;
      exp_result_nxt = rom_vec.exp_result;
      exp_zero_nxt   = rom_vec.exp_zero;
      exp_sign_nxt   = rom_vec.exp_sign;
    end

    busy_nxt = (state_nxt == ST_WAIT) || (state_nxt == ST_CHECK);
    done_nxt = (state_nxt == ST_DONE);
    pass_nxt = done_nxt && (fail_count_nxt == 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 5'd0;
      cnt        <= 4'd0;
      alu_opcode <= 3'd0;
      alu_rega   <= 32'd0;
      alu_regb   <= 32'd0;
      exp_result <= 32'd0;
      exp_zero   <= 1'b0;
      exp_sign   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= 8'd0;
      fail_index <= 5'd0;
    end else begin
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      alu_opcode <= opcode_nxt;
      alu_rega   <= rega_nxt;
      alu_regb   <= regb_nxt;
      exp_result <= exp_result_nxt;
      exp_zero   <= exp_zero_nxt;
      exp_sign   <= exp_sign_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      fail_count <= fail_count_nxt;
      fail_index <= fail_index_nxt;
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: behavioural ALU with injectable faults, two DUTs
// (settle 1 and settle 3), hand-computed vector table and expected outcomes.
module tb_alu_bist;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start3;
  int          fault_mode;

  logic [2:0]  op1, op3;
  logic [31:0] a1, b1, a3, b3;
  logic [31:0] res1, res3;
  logic        zero1, sign1, zero3, sign3;
  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [7:0]  fc1, fc3;
  logic [4:0]  fi1, fi3;

  int n_chk  = 0;
  int n_pass = 0;

  logic [2:0]  tv_op [0:18] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5,
                                3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
  logic [31:0] tv_a  [0:18] = '{32'd0, 32'd1, 32'd2, 32'd1, 32'd5, 32'd4, 32'd4, 32'd5, 32'd4,
                                32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,
                                32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd0, 32'd9};
  logic [31:0] tv_b  [0:18] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd1, 32'd1, 32'd5, 32'd4, 32'd5,
                                32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE,
                                32'hFFFF_FFFF, 32'd2, 32'd0, 32'd2, 32'd0, 32'd5};

  always #5 clk = ~clk;

  // fm 1: sign stuck low on sub 1-2; fm 2: signed compare done unsigned.
  function automatic logic [33:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int fm);
    logic [31:0] r;
    logic        sg;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = {31'd0, a < b};
      3'd5: r = (fm == 2) ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
      default: r = 32'd0;
    endcase
    sg = r[31];
    if (fm == 1 && op == 3'd1 && a == 32'd1 && b == 32'd2) sg = 1'b0;
    return {r, (r == 32'd0), sg};
  endfunction

  always_comb {res1, zero1, sign1} = alu_model(op1, a1, b1, fault_mode);
  always_comb {res3, zero3, sign3} = alu_model(op3, a3, b3, 0);

  alu_bist #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .alu_opcode(op1), .alu_rega(a1), .alu_regb(b1),
    .alu_result(res1), .alu_zero(zero1), .alu_sign(sign1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1), .fail_index(fi1)
  );

  alu_bist #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .alu_opcode(op3), .alu_rega(a3), .alu_regb(b3),
    .alu_result(res3), .alu_zero(zero3), .alu_sign(sign3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3), .fail_index(fi3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Runs dut1 once; counts busy cycles and operand errors against the vector table.
  task automatic run1(input int pulse_a, input int pulse_b, output int cyc,
                      output int op_err, output logic [8:0] at_start);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    at_start = {done1, fc1};
    cyc      = 0;
    op_err   = 0;
    while (busy1 && cyc < 200) begin
      if (cyc < 38) begin
        if (op1 !== tv_op[cyc/2] || a1 !== tv_a[cyc/2] || b1 !== tv_b[cyc/2]) op_err++;
      end
      cyc++;
      start1 = (cyc == pulse_a) || (cyc == pulse_b);
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  initial begin
    int         cyc, op_err;
    logic [8:0] at_start;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; fault_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_fail_count", fc1, 0);
    chk("rst_fail_index", fi1, 0);
    chk("rst_opcode", op1, 0);
    chk("rst_rega", a1, 0);
    chk("rst_regb", b1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run, settle 1
    run1(-1, -1, cyc, op_err, at_start);
    chk("good_busy_cycles", cyc, 38);
    chk("good_operands", op_err, 0);
    chk("good_done", done1, 1);
    chk("good_pass", pass1, 1);
    chk("good_fail_count", fc1, 0);
    chk("final_opcode", op1, 5);
    chk("final_rega", a1, 9);
    chk("final_regb", b1, 5);
    repeat (3) @(negedge clk);
    chk("done_held", done1, 1);

    // Sign stuck low on vector 3 only
    fault_mode = 1;
    run1(-1, -1, cyc, op_err, at_start);
    chk("sign_fault_count", fc1, 1);
    chk("sign_fault_index", fi1, 3);
    chk("sign_fault_pass", pass1, 0);
    chk("sign_fault_done", done1, 1);

    // Rerun from DONE with starts mid-run: counters clear, starts ignored
    fault_mode = 0;
    run1(5, 20, cyc, op_err, at_start);
    chk("rerun_done_cleared", at_start[8], 0);
    chk("rerun_count_cleared", at_start[7:0], 0);
    chk("midstart_busy_cycles", cyc, 38);
    chk("midstart_operands", op_err, 0);
    chk("rerun_pass", pass1, 1);
    chk("rerun_fail_count", fc1, 0);

    // Unsigned signed-compare: (-1<0) and (0<-2) differ from unsigned; (-1<-2) does not
    fault_mode = 2;
    run1(-1, -1, cyc, op_err, at_start);
    chk("sltu_fault_count", fc1, 2);
    chk("sltu_fault_index", fi1, 11);
    chk("sltu_fault_pass", pass1, 0);
    fault_mode = 0;

    // Reset mid-run at busy cycle 17
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_reset_busy", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_done", done1, 0);
    chk("arst_fail_count", fc1, 0);
    chk("arst_fail_index", fi1, 0);
    chk("arst_opcode", op1, 0);
    chk("arst_rega", a1, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_reset_done", done1, 0);
    chk("post_reset_busy", busy1, 0);
    run1(-1, -1, cyc, op_err, at_start);
    chk("post_reset_run_cycles", cyc, 38);
    chk("post_reset_run_pass", pass1, 1);

    // Settle 3: each vector held 4 cycles, 76 busy cycles
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    cyc = 0; op_err = 0;
    while (busy3 && cyc < 300) begin
      if (cyc < 76) begin
        if (op3 !== tv_op[cyc/4] || a3 !== tv_a[cyc/4] || b3 !== tv_b[cyc/4]) op_err++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("s3_busy_cycles", cyc, 76);
    chk("s3_operands", op_err, 0);
    chk("s3_done", done3, 1);
    chk("s3_pass", pass3, 1);
    chk("s3_fail_count", fc3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
